data_memory_sized: RTL and testbench

//  Byte-addressable data memory for the MEM stage of the pipeline.

---
 rtl/data_memory_sized.sv | 104 ++++++++++
 tb/tb_data_memory_sized.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressable MEM-stage data memory: lane-masked stores, registered
// sign/zero-extended loads, and a one-cycle flag for misaligned or illegal accesses.
module data_memory_sized #(
  parameter int B = 32,
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [1:0]   i_size,
  input  logic         i_unsigned,
  input  logic [W+1:0] i_addr,
  input  logic [B-1:0] i_data,
  output logic [B-1:0] o_data,
  output logic         o_valid,
  output logic         o_misaligned
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] r_mem [DEPTH];

  logic [W-1:0] w_idx;
  logic [1:0]   w_lane;
  logic         w_legal;
  logic [3:0]   w_be;
  logic [B-1:0] w_wdata;
  logic [B-1:0] w_rword;
  logic [B-1:0] w_shift;
  logic [B-1:0] w_ext;

  assign w_idx  = i_addr[W+1:2];
  assign w_lane = i_addr[1:0];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = i_data;
    case (i_size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_data[7:0]}};
      end
      2'b01: begin
        w_legal = ~i_addr[0];
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_data[15:0]}};
      end
      2'b10: begin
        w_legal = (w_lane == 2'b00);
        w_be    = 4'b1111;
        w_wdata = i_data;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = i_data;
      end
    endcase
  end

  // Array is not reset; an edge seen while reset is asserted must not write.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_mem_write && w_legal) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_idx];
  assign w_shift = w_rword >> {w_lane, 3'b000};

  always_comb begin
    w_ext = w_rword;
    case (i_size)
      2'b00:   w_ext = {{24{~i_unsigned & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ext = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_rword;
    endcase
  end

  // o_valid marks a completed load for exactly one cycle; there is no
  // back-pressure, so a consumer must capture o_data in the cycle o_valid is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_misaligned <= (i_mem_read | i_mem_write) & ~w_legal;
      if (i_mem_read && !i_mem_write && w_legal) begin
        o_data  <= w_ext;
        o_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: stores, extended loads, illegal
// accesses, write priority, mid-cycle reset and read-after-write.
module tb_data_memory_sized;

  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    size;
  logic          uns;
  logic [W+1:0]  addr;
  logic [31:0]   wdata;
  logic [31:0]   o_data;
  logic          o_valid;
  logic          o_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_sized #(.B(32), .W(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_size       (size),
    .i_unsigned   (uns),
    .i_addr       (addr),
    .i_data       (wdata),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_misaligned (o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one request for one edge; returns 1 ns after the edge.
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic u, input logic [W+1:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    uns       = u;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d,
                            input logic v, input logic m);
    check({tag, ".data"}, o_data, d);
    check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
    check({tag, ".mis"}, {31'd0, o_misaligned}, {31'd0, m});
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1: word store then word load
    op(1'b0, 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
    expect_out("t1_store", 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    expect_out("t1_load", 32'hDEADBEEF, 1'b1, 1'b0);

    // 2: byte store into lane 3, upper store-data bits must be ignored
    op(1'b0, 1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344);
    op(1'b0, 1'b1, 2'b00, 1'b0, 10'h013, 32'h55555580);
    op(1'b1, 1'b0, 2'b00, 1'b0, 10'h013, 32'h0);
    expect_out("t2_lb", 32'hFFFFFF80, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
    expect_out("t2_lbu", 32'h00000080, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    expect_out("t2_lw", 32'h80223344, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b00, 1'b0, 10'h011, 32'h0);
    expect_out("t2_lb1", 32'h00000033, 1'b1, 1'b0);

    // 3: misaligned / illegal accesses
    op(1'b1, 1'b0, 2'b01, 1'b0, 10'h011, 32'h0);
    expect_out("t3_lh_mis", 32'h0, 1'b0, 1'b1);
    op(1'b0, 1'b1, 2'b10, 1'b0, 10'h012, 32'hFFFFFFFF);
    expect_out("t3_sw_mis", 32'h0, 1'b0, 1'b1);
    op(1'b1, 1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
    expect_out("t3_sz11", 32'h0, 1'b0, 1'b1);
    op(1'b0, 1'b1, 2'b11, 1'b0, 10'h010, 32'hFFFFFFFF);
    expect_out("t3_sz11_w", 32'h0, 1'b0, 1'b1);
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    expect_out("t3_unchanged", 32'h80223344, 1'b1, 1'b0);

    // 4: write has priority over a simultaneous read
    op(1'b1, 1'b1, 2'b10, 1'b0, 10'h020, 32'h12345678);
    expect_out("t4_rw", 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    expect_out("t4_raw", 32'h12345678, 1'b1, 1'b0);

    // 5: mid-cycle reset while o_valid is high; store during reset is dropped
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    check("t5_pre_valid", {31'd0, o_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("t5_async", 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b10, 1'b0, 10'h020, 32'hCAFEF00D);
    expect_out("t5_in_rst", 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    expect_out("t5_kept", 32'h12345678, 1'b1, 1'b0);

    // 6: halfword store into upper lanes, signed/unsigned loads
    op(1'b0, 1'b1, 2'b01, 1'b0, 10'h022, 32'h00008001);
    expect_out("t6_sh", 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b01, 1'b0, 10'h022, 32'h0);
    expect_out("t6_lh", 32'hFFFF8001, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b01, 1'b1, 10'h022, 32'h0);
    expect_out("t6_lhu", 32'h00008001, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    expect_out("t6_lw", 32'h80015678, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b01, 1'b0, 10'h020, 32'h0);
    expect_out("t6_lh_lo", 32'h00005678, 1'b1, 1'b0);

    // idle cycle clears outputs
    op(1'b0, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    expect_out("idle", 32'h0, 1'b0, 1'b0);

    // top-of-array address has no wrap
    op(1'b0, 1'b1, 2'b10, 1'b0, 10'h3FC, 32'hA5A5C3C3);
    op(1'b1, 1'b0, 2'b00, 1'b0, 10'h3FF, 32'h0);
    expect_out("top_lb", 32'hFFFFFFA5, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
    check("t1_no_alias", {31'd0, o_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
